// File: rtl/bcd_counter_display.sv
// N-digit up/down BCD counter with a switch-selected prescaler, synchronous
// load/clear, wrap pulse and a multiplexed active-low seven-segment driver.
module bcd_counter_display #(
  parameter int NDIG        = 4,
  parameter int DIV0        = 50000000,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              up,
  input  logic [2:0]        sw,
  input  logic              clear,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
  input  logic              blank_lz,
  output logic [4*NDIG-1:0] count,
  output logic              carry_out,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an
);

  localparam int CW = 4 * NDIG;
  localparam int PW = $clog2(DIV0 + 1);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (NDIG > 1) ? $clog2(NDIG) : 1;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  // Non-BCD nibbles load as zero, digit by digit
  function automatic logic [CW-1:0] sanitize(input logic [CW-1:0] v);
    logic [CW-1:0] res;
    res = v;
    for (int k = 0; k < NDIG; k++) begin
      res[4*k +: 4] = (v[4*k +: 4] > 4'd9) ? 4'd0 : v[4*k +: 4];
    end
    return res;
  endfunction

  logic [CW-1:0]   count_r;
  logic [CW-1:0]   next_count_s;
  logic            carry_r;
  logic            chain_s;
  logic [PW-1:0]   pcnt_r;
  logic [PW-1:0]   limit_s;
  logic            tick_s;
  logic [RW-1:0]   rcnt_r;
  logic [SW-1:0]   sel_r;
  logic [NDIG-1:0] an_r;
  logic [6:0]      seg_r;
  logic [3:0]      cur_digit_s;
  logic            blank_s;
  logic            zero_above_s;

  assign limit_s = PW'(DIV0) >> sw;
  assign tick_s  = en && (pcnt_r >= (limit_s - PW'(1)));

  // Ripple increment/decrement across digits; chain_s left set means a wrap
  always_comb begin
    next_count_s = count_r;
    chain_s      = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      if (chain_s) begin
        if (up) begin
          if (count_r[4*k +: 4] >= 4'd9) begin
            next_count_s[4*k +: 4] = 4'd0;
          end else begin
            next_count_s[4*k +: 4] = count_r[4*k +: 4] + 4'd1;
            chain_s = 1'b0;
          end
        end else begin
          if (count_r[4*k +: 4] == 4'd0) begin
            next_count_s[4*k +: 4] = 4'd9;
          end else begin
            next_count_s[4*k +: 4] = count_r[4*k +: 4] - 4'd1;
            chain_s = 1'b0;
          end
        end
      end else begin
        next_count_s[4*k +: 4] = count_r[4*k +: 4];
      end
    end
  end

  // Counter, prescaler and wrap pulse: clear > load > tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {NDIG{4'd0}};
      pcnt_r  <= {PW{1'b0}};
      carry_r <= 1'b0;
    end else if (clear) begin
      count_r <= {NDIG{4'd0}};
      pcnt_r  <= {PW{1'b0}};
      carry_r <= 1'b0;
    end else if (load) begin
      count_r <= sanitize(load_val);
      pcnt_r  <= {PW{1'b0}};
      carry_r <= 1'b0;
    end else if (tick_s) begin
      count_r <= next_count_s;
      pcnt_r  <= {PW{1'b0}};
      carry_r <= chain_s;
    end else if (en) begin
      pcnt_r  <= pcnt_r + PW'(1);
      carry_r <= 1'b0;
    end else begin
      carry_r <= 1'b0;
    end
  end

  // Digit under the current slot and whether it is a blanked leading zero
  always_comb begin
    cur_digit_s  = 4'd0;
    blank_s      = 1'b0;
    zero_above_s = 1'b1;
    for (int k = NDIG - 1; k >= 0; k--) begin
      zero_above_s = zero_above_s && (count_r[4*k +: 4] == 4'd0);
      cur_digit_s  = cur_digit_s | ((SW'(k) == sel_r) ? count_r[4*k +: 4] : 4'd0);
      blank_s      = blank_s | ((SW'(k) == sel_r) && blank_lz && zero_above_s && (k != 0));
    end
  end

  // Refresh timer, digit selector and registered display drive
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt_r <= {RW{1'b0}};
      sel_r  <= {SW{1'b0}};
      an_r   <= ~(NDIG'(1));
      seg_r  <= 7'b1000000;
    end else begin
      if (rcnt_r == RW'(REFRESH_DIV - 1)) begin
        rcnt_r <= {RW{1'b0}};
        sel_r  <= (sel_r == SW'(NDIG - 1)) ? {SW{1'b0}} : sel_r + SW'(1);
      end else begin
        rcnt_r <= rcnt_r + RW'(1);
      end
      an_r  <= blank_s ? {NDIG{1'b1}} : ~(NDIG'(1) << sel_r);
      seg_r <= blank_s ? 7'b1111111 : glyph(cur_digit_s);
    end
  end

  assign count     = count_r;
  assign carry_out = carry_r;
  assign an        = an_r;
  assign seg       = seg_r;

endmodule
